cfa_diag_seq: RTL and testbench
===============================

CFA_DIAG_SEQ -- requirements
Module: cfa_diag_seq

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image width in pixels; even, >=4.
REQ-002 SHALL have parameter IMG_H, default 64, image height in pixels; even, >=4.
REQ-003 SHALL have parameter PIX_W, default 12, pixel width.
REQ-004 SHALL have parameter EQU_LAT, default 1, cycles from op_valid to eq_result valid.
REQ-005 SHALL have derived constant AW = clog2(IMG_W*IMG_H), the address width.
REQ-006 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  in  1  one-cycle frame start request.
REQ-009 SHALL have port busy  out  1  high from accepted start until done.
REQ-010 SHALL have port done  out  1  one-cycle pulse after the last result is accepted.
REQ-011 SHALL have port mem_req  out  1  pixel read request.
REQ-012 SHALL have port mem_plane  out  1  plane select: 0=G, 1=RB.
REQ-013 SHALL have port mem_addr  out  AW  read address = y*IMG_W+x.
REQ-014 SHALL have port mem_rdata  in  PIX_W  read data, valid exactly 1 cycle after mem_req.
REQ-015 SHALL have port op_g  out  4*PIX_W  packed {pp,pm,mp,mm} G operands to equ_24_27.
REQ-016 SHALL have port op_rb  out  4*PIX_W  packed {pp,pm,mp,mm} RB operands.
REQ-017 SHALL have port op_valid  out  1  one-cycle pulse when operands are complete.
REQ-018 SHALL have port eq_result  in  PIX_W  equ_24_27 output.
REQ-019 SHALL have port res_valid  out  1  result available.
REQ-020 SHALL have port res_ready  in  1  downstream accepts the result.
REQ-021 SHALL have port res_addr  out  AW  site address of the result.
REQ-022 SHALL have port res_data  out  PIX_W  captured result.

Function
REQ-023 SHALL visit sites in raster order: y=1..IMG_H-2, x=1..IMG_W-2, restricted to sites with (x+y) even.
REQ-024 SHALL read neighbours in the fixed order G mm, mp, pm, pp, then RB mm, mp, pm, pp; mm=(y-1,x-1), mp=(y-1,x+1), pm=(y+1,x-1), pp=(y+1,x+1).
REQ-025 SHALL use FSM states IDLE, FETCH, CALC, OUT, NEXT.
- IDLE: start -> FETCH at the first site.
- FETCH -> CALC after the 8th read datum is captured.
- CALC -> OUT after EQU_LAT cycles.
- OUT -> NEXT when res_ready is high.
- NEXT -> FETCH if sites remain; otherwise -> IDLE with done.
REQ-026 SHALL assert mem_req on 8 consecutive FETCH cycles and capture mem_rdata one cycle after each request.
REQ-027 SHALL pulse op_valid on the CALC entry cycle and hold op_g/op_rb stable through CALC.
REQ-028 SHALL capture eq_result into res_data on the final CALC cycle.
REQ-029 SHALL hold res_valid, res_addr and res_data stable in OUT until res_ready is high; no mem_req is issued while stalled.
REQ-030 SHALL ignore start while busy.
REQ-031 SHALL complete each site in 11+EQU_LAT cycles when res_ready is tied high.
REQ-032 SHALL produce exactly (IMG_W-2)*(IMG_H-2)/2 results per frame.
REQ-033 SHALL accept start in the same cycle done pulses only once in IDLE, i.e. on the following cycle.

Reset
REQ-034 SHALL, on rst low at any time including mid-frame, enter IDLE immediately and drive busy, done, mem_req, op_valid and res_valid to 0.
REQ-035 SHALL reset mem_addr, mem_plane, op_g, op_rb, res_addr, res_data and the x/y counters to 0.
REQ-036 SHALL NOT resume an interrupted frame after reset release; a new start is required.

Structure
REQ-037 SHALL take FSM state encoding, neighbour-order indices and PIX_W from a shared package cfa_pkg.
REQ-038 SHALL instantiate one sub-module, cfa_site_cnt, as the x/y raster counter with parity skip and last-site flag.
REQ-039 SHALL NOT instantiate equ_24_27; it connects externally.

Verification
REQ-040 SHALL verify: 4x4 image, start -> read addresses 0,2,8,10 (G then RB) for site 5, then 5,7,13,15 for site 10; exactly 2 results; then done.
REQ-041 SHALL verify: G plane all 100, RB plane all 60, with real equ_24_27 attached -> res_data=40 for both sites.
REQ-042 SHALL verify: res_ready held low for 20 cycles at the first OUT -> res_valid/res_addr=5 stable, no mem_req, then resumes normally.
REQ-043 SHALL verify: start pulsed at cycle 5 of FETCH -> ignored; result count unchanged.
REQ-044 SHALL verify: rst low during the second site's FETCH -> all outputs 0 immediately; new start restarts at site 5.
REQ-045 SHALL verify: 64x64 image with res_ready tied high -> 1922 results; busy lasts 1922*(11+EQU_LAT) cycles within +/-2.

Source files
------------

// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA diagonal neighbour sequencer: FSM encoding,
// neighbour fetch order and default pixel width.
package cfa_pkg;

    localparam int PIX_W_DEF = 12;
    localparam int N_NB      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CALC,
        ST_OUT,
        ST_NEXT
    } state_t;

    // Neighbour index within one plane; fetch index bit 2 selects the plane.
    localparam logic [1:0] NB_MM = 2'd0;
    localparam logic [1:0] NB_MP = 2'd1;
    localparam logic [1:0] NB_PM = 2'd2;
    localparam logic [1:0] NB_PP = 2'd3;

    localparam logic PLANE_G  = 1'b0;
    localparam logic PLANE_RB = 1'b1;

endpackage

// File: rtl/cfa_site_cnt.sv
// Raster walker over interior sites with (x+y) even; flags the final site.
module cfa_site_cnt #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic row_end;

    assign row_end = (int'(x) + 2) > (IMG_W - 2);
    assign last    = row_end && (int'(y) == IMG_H - 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= XW'(1);
            y <= YW'(1);
        end else if (step) begin
            if (row_end) begin
                // Next row keeps parity even: odd row starts at x=1, even row at x=2.
                y <= y + YW'(1);
                x <= y[0] ? XW'(2) : XW'(1);
            end else begin
                x <= x + XW'(2);
            end
        end
    end

endmodule

// File: rtl/cfa_diag_seq.sv
// Per-site sequencer: fetches the 8 diagonal neighbours (G then RB), presents
// them to the external equ_24_27 unit and hands the result downstream.
module cfa_diag_seq
    import cfa_pkg::*;
#(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int EQU_LAT = 1,
    localparam int AW = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_req,
    output logic               mem_plane,
    output logic [AW-1:0]      mem_addr,
    input  logic [PIX_W-1:0]   mem_rdata,
    output logic [4*PIX_W-1:0] op_g,
    output logic [4*PIX_W-1:0] op_rb,
    output logic               op_valid,
    input  logic [PIX_W-1:0]   eq_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [AW-1:0]      res_addr,
    output logic [PIX_W-1:0]   res_data,
    output state_t             dbg_state
);

    // Handshake: a result transfers on any rising edge where res_valid and
    // res_ready are both high; res_valid/res_addr/res_data do not change until then.

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int LW = (EQU_LAT > 1) ? $clog2(EQU_LAT) : 1;

    state_t          state;
    logic [3:0]      rd_cnt;
    logic [LW-1:0]   lat_cnt;
    logic            final_site;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            last;
    logic            cnt_load;
    logic            cnt_step;
    logic [2:0]      nxt_idx;
    logic [2:0]      cap_idx;
    logic [AW-1:0]   site_addr;

    function automatic logic [AW-1:0] nb_addr(input logic [XW-1:0] cx,
                                              input logic [YW-1:0] cy,
                                              input logic [1:0]    j);
        int ax;
        int ay;
        ax = int'(cx) + ((j == NB_MP || j == NB_PP) ? 1 : -1);
        ay = int'(cy) + ((j == NB_PM || j == NB_PP) ? 1 : -1);
        return AW'(ay * IMG_W + ax);
    endfunction

    assign cnt_load  = (state == ST_IDLE) && start;
    assign cnt_step  = (state == ST_OUT) && res_ready && !last;
    assign nxt_idx   = 3'(rd_cnt + 4'd1);
    assign cap_idx   = 3'(rd_cnt - 4'd1);
    assign site_addr = AW'(int'(y) * IMG_W + int'(x));
    assign dbg_state = state;

    cfa_site_cnt #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) u_site_cnt (
        .clk (clk),
        .rst (rst),
        .load(cnt_load),
        .step(cnt_step),
        .x   (x),
        .y   (y),
        .last(last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_req    <= 1'b0;
            mem_plane  <= 1'b0;
            mem_addr   <= '0;
            op_g       <= '0;
            op_rb      <= '0;
            op_valid   <= 1'b0;
            res_valid  <= 1'b0;
            res_addr   <= '0;
            res_data   <= '0;
            rd_cnt     <= '0;
            lat_cnt    <= '0;
            final_site <= 1'b0;
        end else begin
            done     <= 1'b0;
            op_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // First site is always (1,1); its mm neighbour is address 0.
                        state     <= ST_FETCH;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_plane <= PLANE_G;
                        mem_addr  <= nb_addr(XW'(1), YW'(1), NB_MM);
                        rd_cnt    <= '0;
                    end
                end
                ST_FETCH: begin
                    rd_cnt <= rd_cnt + 4'd1;
                    if (rd_cnt != 4'd0) begin
                        if (cap_idx[2] == PLANE_RB)
                            op_rb[int'(cap_idx[1:0]) * PIX_W +: PIX_W] <= mem_rdata;
                        else
                            op_g[int'(cap_idx[1:0]) * PIX_W +: PIX_W] <= mem_rdata;
                    end
                    if (rd_cnt < 4'(N_NB - 1)) begin
                        mem_plane <= nxt_idx[2];
                        mem_addr  <= nb_addr(x, y, nxt_idx[1:0]);
                    end else begin
                        mem_req <= 1'b0;
                    end
                    if (rd_cnt == 4'(N_NB)) begin
                        state    <= ST_CALC;
                        op_valid <= 1'b1;
                        lat_cnt  <= '0;
                    end
                end
                ST_CALC: begin
                    if (lat_cnt == LW'(EQU_LAT - 1)) begin
                        res_data  <= eq_result;
                        res_addr  <= site_addr;
                        res_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        final_site <= last;
                        state      <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (final_site) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= ST_FETCH;
                        mem_req   <= 1'b1;
                        mem_plane <= PLANE_G;
                        mem_addr  <= nb_addr(x, y, NB_MM);
                        rd_cnt    <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfa_diag_seq.sv
// Bench for cfa_diag_seq: a 4x4 instance for directed/random frames and a
// 64x64 instance for the full-frame count and throughput.
module tb_cfa_diag_seq;
    import cfa_pkg::*;

    localparam int PW      = 12;
    localparam int EQU_LAT = 1;
    localparam int SW = 4,  SH = 4,  SAW = $clog2(SW * SH);
    localparam int BW = 64, BH = 64, BAW = $clog2(BW * BH);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stand-in for equ_24_27: mean of the G diagonals minus mean of the RB
    // diagonals, clamped to the pixel range.
    function automatic logic [PW-1:0] equ(input int gs, input int rs);
        int d;
        d = (gs - rs) >>> 2;
        if (d < 0) d = 0;
        if (d > (1 << PW) - 1) d = (1 << PW) - 1;
        return PW'(d);
    endfunction

    function automatic int psum(input logic [4*PW-1:0] v);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(v[i*PW +: PW]);
        return s;
    endfunction

    // Neighbour k of site (x,y): k/4 is the plane, k%4 walks mm, mp, pm, pp.
    function automatic int nb_of(input int x, input int y, input int w, input int k);
        int j = k % 4;
        return (y + ((j >= 2) ? 1 : -1)) * w + x + ((j % 2 == 1) ? 1 : -1);
    endfunction

    // ---------------- small instance ----------------
    logic s_start, s_busy, s_done, s_req, s_plane, s_opv, s_rvalid, s_rready;
    logic [SAW-1:0]  s_addr, s_raddr;
    logic [PW-1:0]   s_mem_rd, s_eq, s_res_data;
    logic [4*PW-1:0] s_opg, s_oprb;
    state_t          s_state;
    logic [PW-1:0]   s_g [SW*SH];
    logic [PW-1:0]   s_rb[SW*SH];

    cfa_diag_seq #(.IMG_W(SW), .IMG_H(SH), .PIX_W(PW), .EQU_LAT(EQU_LAT)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .mem_req(s_req), .mem_plane(s_plane), .mem_addr(s_addr), .mem_rdata(s_mem_rd),
        .op_g(s_opg), .op_rb(s_oprb), .op_valid(s_opv), .eq_result(s_eq),
        .res_valid(s_rvalid), .res_ready(s_rready), .res_addr(s_raddr),
        .res_data(s_res_data), .dbg_state(s_state)
    );

    always @(posedge clk) s_mem_rd <= s_req ? (s_plane ? s_rb[s_addr] : s_g[s_addr]) : '0;
    always_comb s_eq = equ(psum(s_opg), psum(s_oprb));

    // ---------------- large instance ----------------
    logic b_start, b_busy, b_done, b_req, b_plane, b_opv, b_rvalid;
    logic b_rready = 1'b1;
    logic [BAW-1:0]  b_addr, b_raddr;
    logic [PW-1:0]   b_mem_rd, b_eq, b_res_data;
    logic [4*PW-1:0] b_opg, b_oprb;
    state_t          b_state;
    logic [PW-1:0]   b_g [BW*BH];
    logic [PW-1:0]   b_rb[BW*BH];

    cfa_diag_seq #(.IMG_W(BW), .IMG_H(BH), .PIX_W(PW), .EQU_LAT(EQU_LAT)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_req(b_req), .mem_plane(b_plane), .mem_addr(b_addr), .mem_rdata(b_mem_rd),
        .op_g(b_opg), .op_rb(b_oprb), .op_valid(b_opv), .eq_result(b_eq),
        .res_valid(b_rvalid), .res_ready(b_rready), .res_addr(b_raddr),
        .res_data(b_res_data), .dbg_state(b_state)
    );

    always @(posedge clk) b_mem_rd <= b_req ? (b_plane ? b_rb[b_addr] : b_g[b_addr]) : '0;
    always_comb b_eq = equ(psum(b_opg), psum(b_oprb));

    // ---------------- scoreboard ----------------
    logic [31:0] s_rd_q[$];
    logic [31:0] s_res_q[$];
    logic [31:0] b_res_q[$];
    int s_exp_n, s_nres, s_ndone, s_nop, s_last_data;
    int b_exp_n, b_nres, b_ndone, b_busy_cyc;
    bit s_prev_stall;
    logic [SAW-1:0] s_prev_addr;
    logic [PW-1:0]  s_prev_data;

    task automatic build_small_exp();
        s_rd_q.delete();
        s_res_q.delete();
        for (int y = 1; y <= SH - 2; y++)
            for (int x = 1; x <= SW - 2; x++)
                if ((x + y) % 2 == 0) begin
                    int gs = 0;
                    int rs = 0;
                    for (int k = 0; k < 8; k++) begin
                        int a = nb_of(x, y, SW, k);
                        s_rd_q.push_back(32'((k / 4) * 256 + a));
                        if (k < 4) gs += int'(s_g[a]); else rs += int'(s_rb[a]);
                    end
                    s_res_q.push_back(32'((y * SW + x) * 65536 + int'(equ(gs, rs))));
                end
        s_exp_n = s_res_q.size();
    endtask

    task automatic build_big_exp();
        b_res_q.delete();
        for (int y = 1; y <= BH - 2; y++)
            for (int x = 1; x <= BW - 2; x++)
                if ((x + y) % 2 == 0) begin
                    int gs = 0;
                    int rs = 0;
                    for (int k = 0; k < 8; k++) begin
                        int a = nb_of(x, y, BW, k);
                        if (k < 4) gs += int'(b_g[a]); else rs += int'(b_rb[a]);
                    end
                    b_res_q.push_back(32'((y * BW + x) * 65536 + int'(equ(gs, rs))));
                end
        b_exp_n = b_res_q.size();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            s_prev_stall = 1'b0;
        end else begin
            if (s_req) begin
                if (s_rd_q.size() == 0) check("s_rd_extra", 1, 0);
                else check("s_rd_addr", int'(s_plane) * 256 + int'(s_raddr_dummy(s_addr)), s_rd_q.pop_front());
            end
            if (s_rvalid) check("s_no_req_in_out", s_req, 0);
            if (s_prev_stall) begin
                check("s_hold_valid", s_rvalid, 1);
                check("s_hold_addr", s_raddr, s_prev_addr);
                check("s_hold_data", s_res_data, s_prev_data);
            end
            if (s_rvalid && s_rready) begin
                if (s_res_q.size() == 0) check("s_res_extra", 1, 0);
                else check("s_res", int'(s_raddr) * 65536 + int'(s_res_data), s_res_q.pop_front());
                s_nres++;
                s_last_data = int'(s_res_data);
            end
            s_prev_stall = s_rvalid && !s_rready;
            s_prev_addr  = s_raddr;
            s_prev_data  = s_res_data;
            if (s_done) s_ndone++;
            if (s_opv)  s_nop++;

            if (b_rvalid && b_rready) begin
                if (b_res_q.size() == 0) check("b_res_extra", 1, 0);
                else check("b_res", int'(b_raddr) * 65536 + int'(b_res_data), b_res_q.pop_front());
                b_nres++;
            end
            if (b_busy) b_busy_cyc++;
            if (b_done) b_ndone++;
        end
    end

    function automatic logic [SAW-1:0] s_raddr_dummy(input logic [SAW-1:0] a);
        return a;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_small();
        build_small_exp();
        s_nres  = 0;
        s_ndone = 0;
        s_nop   = 0;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
    endtask

    task automatic fill_small_random();
        for (int i = 0; i < SW * SH; i++) begin
            s_g[i]  = PW'($urandom_range(0, (1 << PW) - 1));
            s_rb[i] = PW'($urandom_range(0, (1 << PW) - 1));
        end
    endtask

    // mode 0: plain, 1: extra start in FETCH cycle 5, 2: 20-cycle stall at first OUT
    task automatic run_small(input int mode);
        int t;
        s_rready = (mode != 2);
        start_small();
        if (mode == 1) begin
            repeat (4) @(posedge clk);
            #1 s_start = 1'b1;
            @(posedge clk); #1 s_start = 1'b0;
        end
        if (mode == 2) begin
            t = 0;
            while (!s_rvalid && t < 100) begin @(posedge clk); #1; t++; end
            check("s_stall_reach", s_rvalid, 1);
            check("s_stall_addr", s_raddr, 5);
            repeat (20) @(posedge clk);
            #1 s_rready = 1'b1;
        end
        t = 0;
        while (s_ndone == 0 && t < 2000) begin @(posedge clk); t++; end
        repeat (2) @(posedge clk);
        #1;
        check("s_done_pulses", s_ndone, 1);
        check("s_result_count", s_nres, s_exp_n);
        check("s_op_valid_count", s_nop, s_exp_n);
        check("s_reads_left", s_rd_q.size(), 0);
        check("s_results_left", s_res_q.size(), 0);
        check("s_busy_after", s_busy, 0);
        s_rready = 1'b1;
    endtask

    task automatic check_small_zero(input string tag);
        check({tag, "_busy"}, s_busy, 0);
        check({tag, "_done"}, s_done, 0);
        check({tag, "_req"}, s_req, 0);
        check({tag, "_opv"}, s_opv, 0);
        check({tag, "_rvalid"}, s_rvalid, 0);
        check({tag, "_addr"}, s_addr, 0);
        check({tag, "_plane"}, s_plane, 0);
        check({tag, "_opg"}, s_opg, 0);
        check({tag, "_oprb"}, s_oprb, 0);
        check({tag, "_raddr"}, s_raddr, 0);
        check({tag, "_rdata"}, s_res_data, 0);
        check({tag, "_state"}, s_state, ST_IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        s_start  = 1'b0;
        s_rready = 1'b1;
        b_start  = 1'b0;
        b_nres = 0; b_ndone = 0; b_busy_cyc = 0;
        s_nres = 0; s_ndone = 0; s_nop = 0; s_last_data = 0;
        fill_small_random();
        for (int i = 0; i < BW * BH; i++) begin
            b_g[i]  = PW'($urandom_range(0, (1 << PW) - 1));
            b_rb[i] = PW'($urandom_range(0, (1 << PW) - 1));
        end

        repeat (3) @(posedge clk);
        #1;
        check_small_zero("rst");
        check("rst_b_busy", b_busy, 0);
        rst = 1'b1;

        // Random frames: address order and results against the model.
        for (int r = 0; r < 3; r++) begin
            fill_small_random();
            run_small(0);
        end

        // Flat planes: G=100, RB=60 gives 40 at every site.
        for (int i = 0; i < SW * SH; i++) begin
            s_g[i]  = PW'(100);
            s_rb[i] = PW'(60);
        end
        run_small(0);
        check("s_flat_result", s_last_data, 40);

        fill_small_random();
        run_small(2);

        fill_small_random();
        run_small(1);

        // Reset during the second site's FETCH, then a fresh frame.
        fill_small_random();
        start_small();
        t = 0;
        while (s_nres < 1 && t < 500) begin @(posedge clk); #1; t++; end
        while (s_state != ST_FETCH && t < 500) begin @(posedge clk); #1; t++; end
        check("mid_reach_second_fetch", s_state, ST_FETCH);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_small_zero("mid_rst");
        s_rd_q.delete();
        s_res_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_resume_busy", s_busy, 0);
        check("no_resume_req", s_req, 0);
        run_small(0);

        // Full 64x64 frame with res_ready tied high.
        build_big_exp();
        b_nres = 0; b_ndone = 0; b_busy_cyc = 0;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        t = 0;
        while (b_ndone == 0 && t < 60000) begin @(posedge clk); t++; end
        repeat (2) @(posedge clk);
        #1;
        check("b_done_pulses", b_ndone, 1);
        check("b_result_count", b_nres, b_exp_n);
        check("b_result_count_abs", b_nres, (BW - 2) * (BH - 2) / 2);
        check("b_results_left", b_res_q.size(), 0);
        $display("big frame busy cycles: %0d (nominal %0d)", b_busy_cyc, b_exp_n * (11 + EQU_LAT));
        check("b_busy_window",
              (b_busy_cyc >= b_exp_n * (11 + EQU_LAT) - 2) && (b_busy_cyc <= b_exp_n * (11 + EQU_LAT) + 2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
